// File: rtl/idx_seq_pkg.sv
// Shared definitions for the indexed-load/store sequencer.
package idx_seq_pkg;

  // Sequencer states.
  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetchD = 3'd1,
    StCalc   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StDone   = 3'd5
  } state_e;

  // Z80 8-bit register codes as they appear in the r field of the opcode.
  localparam logic [2:0] RegB = 3'd0;
  localparam logic [2:0] RegC = 3'd1;
  localparam logic [2:0] RegD = 3'd2;
  localparam logic [2:0] RegE = 3'd3;
  localparam logic [2:0] RegH = 3'd4;
  localparam logic [2:0] RegL = 3'd5;
  localparam logic [2:0] RegA = 3'd7;

  // Code 6 selects (HL) in the plain encoding and has no meaning here.
  localparam logic [2:0] REG_ILLEGAL = 3'd6;

  // Number of internal address-calculation cycles.
  localparam int unsigned CALC_CYCLES = 5;
  localparam int unsigned CntW = 3;

  // Two's-complement widening of the displacement byte.
  function automatic logic [15:0] sext8(input logic [7:0] v);
    return {{8{v[7]}}, v};
  endfunction

endpackage

// File: rtl/idx_ea_adder.sv
// Effective-address adder: 16-bit base plus sign-extended 8-bit displacement.
module idx_ea_adder
  import idx_seq_pkg::*;
(
  input  logic [15:0] base_i,
  input  logic [7:0]  disp_i,
  output logic [15:0] ea_o
);

  // Wraps modulo 2^16, matching the CPU's address arithmetic.
  assign ea_o = base_i + sext8(disp_i);

endmodule

// File: rtl/idx_disp_sequencer.sv
// Sequencer for LD r,(IX/IY+d) and LD (IX/IY+d),r: fetches the displacement,
// spends a fixed number of cycles forming the effective address, performs the
// memory access and, for loads, writes the register file.
module idx_disp_sequencer
  import idx_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_Y,
  input  logic        dir_store,
  input  logic [2:0]  reg_sel,
  input  logic [15:0] ix,
  input  logic [15:0] iy,
  input  logic [15:0] pc,
  input  logic [7:0]  reg_rdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ready,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [7:0]  mem_wdata,
  output logic        pc_inc,
  output logic        reg_we,
  output logic [2:0]  reg_waddr,
  output logic [7:0]  reg_wdata,
  output logic [15:0] wz,
  output logic        busy,
  output logic        done,
  output logic        err_illegal
);

  state_e state_q, state_d;

  logic            is_y_q;
  logic            store_q;
  logic [2:0]      sel_q;
  logic [15:0]     wz_q;
  logic [7:0]      wdata_q;
  logic [7:0]      ldata_q;
  logic [CntW-1:0] cnt_q;
  logic            err_q;

  logic            start_ok;
  logic            start_bad;
  logic            calc_last;
  logic [15:0]     base;
  logic [15:0]     ea;

  // Starts are only honoured in IDLE; anything arriving while busy is dropped.
  assign start_ok  = (state_q == StIdle) && start && (reg_sel != REG_ILLEGAL);
  assign start_bad = (state_q == StIdle) && start && (reg_sel == REG_ILLEGAL);
  assign calc_last = (state_q == StCalc) && (cnt_q == '0);

  assign base = is_y_q ? iy : ix;

  idx_ea_adder u_ea_adder (
    .base_i (base),
    .disp_i (mem_rdata),
    .ea_o   (ea)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start_ok) state_d = StFetchD;
      end
      StFetchD: begin
        if (mem_ready) state_d = StCalc;
      end
      StCalc: begin
        if (calc_last) state_d = StMem;
      end
      StMem: begin
        if (mem_ready) state_d = store_q ? StDone : StWb;
      end
      StWb: begin
        state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Moore outputs plus the handshake-qualified PC increment.
  always_comb begin
    mem_addr = 16'h0000;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    pc_inc   = 1'b0;
    reg_we   = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    unique case (state_q)
      StIdle: begin
        busy = 1'b0;
      end
      StFetchD: begin
        mem_addr = pc;
        mem_rd   = 1'b1;
        pc_inc   = mem_ready;
      end
      StCalc: begin
      end
      StMem: begin
        mem_addr = wz_q;
        mem_rd   = ~store_q;
        mem_wr   = store_q;
      end
      StWb: begin
        reg_we = 1'b1;
      end
      StDone: begin
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // Operation latches and the CALC down-counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      is_y_q  <= 1'b0;
      store_q <= 1'b0;
      sel_q   <= 3'd0;
      cnt_q   <= '0;
    end else begin
      if (start_ok) begin
        is_y_q  <= is_Y;
        store_q <= dir_store;
        sel_q   <= reg_sel;
      end
      if ((state_q == StFetchD) && mem_ready) begin
        cnt_q <= CntW'(CALC_CYCLES - 1);
      end else if ((state_q == StCalc) && (cnt_q != '0)) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  // Data path: effective address, store data, load data, illegal flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wz_q    <= 16'h0000;
      wdata_q <= 8'h00;
      ldata_q <= 8'h00;
      err_q   <= 1'b0;
    end else begin
      err_q <= start_bad;
      // The displacement byte feeds the adder straight from the bus, so WZ
      // is already settled on the first CALC cycle.
      if ((state_q == StFetchD) && mem_ready) begin
        wz_q <= ea;
      end
      if (calc_last && store_q) begin
        wdata_q <= reg_rdata;
      end
      if ((state_q == StMem) && mem_ready && !store_q) begin
        ldata_q <= mem_rdata;
      end
    end
  end

  assign mem_wdata   = wdata_q;
  assign reg_waddr   = sel_q;
  assign reg_wdata   = ldata_q;
  assign wz          = wz_q;
  assign err_illegal = err_q;

endmodule

// File: tb/tb_idx_disp_sequencer.sv
// Directed bench for idx_disp_sequencer: a vector table of complete
// transactions plus hand sequences for illegal code, wait states, busy start
// and mid-operation reset.
module tb_idx_disp_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        is_Y;
  logic        dir_store;
  logic [2:0]  reg_sel;
  logic [15:0] ix, iy, pc;
  logic [7:0]  reg_rdata;
  logic [7:0]  mem_rdata;
  logic        mem_ready;
  logic [15:0] mem_addr;
  logic        mem_rd, mem_wr;
  logic [7:0]  mem_wdata;
  logic        pc_inc;
  logic        reg_we;
  logic [2:0]  reg_waddr;
  logic [7:0]  reg_wdata;
  logic [15:0] wz;
  logic        busy, done, err_illegal;

  always #5 clk = ~clk;

  idx_disp_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .is_Y        (is_Y),
    .dir_store   (dir_store),
    .reg_sel     (reg_sel),
    .ix          (ix),
    .iy          (iy),
    .pc          (pc),
    .reg_rdata   (reg_rdata),
    .mem_rdata   (mem_rdata),
    .mem_ready   (mem_ready),
    .mem_addr    (mem_addr),
    .mem_rd      (mem_rd),
    .mem_wr      (mem_wr),
    .mem_wdata   (mem_wdata),
    .pc_inc      (pc_inc),
    .reg_we      (reg_we),
    .reg_waddr   (reg_waddr),
    .reg_wdata   (reg_wdata),
    .wz          (wz),
    .busy        (busy),
    .done        (done),
    .err_illegal (err_illegal)
  );

  // Memory model: displacement byte lives at PC, operand byte everywhere else.
  logic [7:0] cur_d, cur_memv;
  int         n_wait;
  int         req_age;

  assign mem_rdata = (mem_addr == pc) ? cur_d : cur_memv;
  assign mem_ready = (req_age >= n_wait);

  always @(posedge clk) begin
    if (rst) req_age <= 0;
    else if ((mem_rd || mem_wr) && !mem_ready) req_age <= req_age + 1;
    else req_age <= 0;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        is_y;
    logic        store;
    logic [2:0]  sel;
    logic [15:0] ix;
    logic [15:0] iy;
    logic [15:0] pc;
    logic [7:0]  d;
    logic [7:0]  memv;
    logic [7:0]  rdat;
    logic [15:0] exp_wz;
    int          exp_done;
  } vec_t;

  // Observations from the last transaction.
  int          done_cyc, done_n, we_cyc, we_n, wr_n, pcinc_n, both_n, busy_after;
  logic [2:0]  we_addr;
  logic [7:0]  we_data, wr_data;
  logic [15:0] wr_addr, wz_calc;

  task automatic run_txn(input vec_t v, input int inj_cyc);
    done_cyc = -1; done_n = 0; we_cyc = -1; we_n = 0; wr_n = 0;
    pcinc_n = 0; both_n = 0; busy_after = -1;
    we_addr = '0; we_data = '0; wr_data = '0; wr_addr = '0; wz_calc = '0;
    @(negedge clk);
    is_Y = v.is_y; dir_store = v.store; reg_sel = v.sel;
    ix = v.ix; iy = v.iy; pc = v.pc;
    cur_d = v.d; cur_memv = v.memv; reg_rdata = v.rdat;
    start = 1'b1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (cyc == 1) start = 1'b0;
      if (cyc == 2) wz_calc = wz;
      if (pc_inc) pcinc_n++;
      if (mem_rd && mem_wr) both_n++;
      if (reg_we) begin
        we_n++; we_cyc = cyc; we_addr = reg_waddr; we_data = reg_wdata;
      end
      if (mem_wr) begin
        wr_n++; wr_addr = mem_addr; wr_data = mem_wdata;
      end
      if (done) begin
        done_n++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (done_cyc > 0 && cyc == done_cyc + 1) busy_after = int'(busy);
      // A second start while busy, with a different register code.
      if (inj_cyc > 0 && cyc == inj_cyc) begin
        start = 1'b1; reg_sel = 3'd1; dir_store = ~v.store;
      end
      if (inj_cyc > 0 && cyc == inj_cyc + 1) start = 1'b0;
    end
  endtask

  task automatic check_txn(input vec_t v, input int exp_done, input string tag);
    chk({tag, " done_cycle"}, done_cyc, exp_done);
    chk({tag, " done_count"}, done_n, 1);
    chk({tag, " pc_inc_count"}, pcinc_n, 1);
    chk({tag, " rd_wr_overlap"}, both_n, 0);
    chk({tag, " wz_final"}, wz, v.exp_wz);
    chk({tag, " busy_after_done"}, busy_after, 0);
    if (!v.store) begin
      chk({tag, " we_count"}, we_n, 1);
      chk({tag, " we_cycle"}, we_cyc, exp_done - 1);
      chk({tag, " waddr"}, we_addr, v.sel);
      chk({tag, " wdata"}, we_data, v.memv);
      chk({tag, " wr_count"}, wr_n, 0);
    end else begin
      chk({tag, " we_count"}, we_n, 0);
      chk({tag, " wr_count"}, wr_n, 1);
      chk({tag, " wr_addr"}, wr_addr, v.exp_wz);
      chk({tag, " wr_data"}, wr_data, v.rdat);
    end
  endtask

  task automatic check_idle_reset(input string tag);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " mem_rd"}, mem_rd, 0);
    chk({tag, " mem_wr"}, mem_wr, 0);
    chk({tag, " pc_inc"}, pc_inc, 0);
    chk({tag, " reg_we"}, reg_we, 0);
    chk({tag, " done"}, done, 0);
    chk({tag, " err"}, err_illegal, 0);
    chk({tag, " mem_addr"}, mem_addr, 16'h0000);
    chk({tag, " wz"}, wz, 16'h0000);
    chk({tag, " mem_wdata"}, mem_wdata, 8'h00);
    chk({tag, " reg_wdata"}, reg_wdata, 8'h00);
    chk({tag, " reg_waddr"}, reg_waddr, 3'd0);
  endtask

  vec_t vecs[6];
  int   cnt_we, cnt_done, cnt_pc;

  initial begin
    //        is_y  st   sel   ix        iy        pc        d      memv   rdat   wz      done
    vecs[0] = '{1'b0, 1'b0, 3'd7, 16'h1000, 16'h0000, 16'h0100, 8'h05, 8'hAB, 8'h00, 16'h1005, 9};
    vecs[1] = '{1'b1, 1'b1, 3'd0, 16'h4444, 16'h0000, 16'h0200, 8'hFF, 8'h00, 8'h3C, 16'hFFFF, 8};
    vecs[2] = '{1'b0, 1'b0, 3'd2, 16'hFFFF, 16'h0000, 16'h0300, 8'h01, 8'h5A, 8'h00, 16'h0000, 9};
    vecs[3] = '{1'b0, 1'b1, 3'd5, 16'h8000, 16'h0000, 16'h0400, 8'h80, 8'h00, 8'hC3, 16'h7F80, 8};
    vecs[4] = '{1'b1, 1'b0, 3'd4, 16'hABCD, 16'h1234, 16'h0500, 8'h7F, 8'h99, 8'h00, 16'h12B3, 9};
    vecs[5] = '{1'b0, 1'b1, 3'd3, 16'h2000, 16'h5555, 16'h0600, 8'hFE, 8'h00, 8'h11, 16'h1FFE, 8};

    rst = 1'b1; start = 1'b0; is_Y = 1'b0; dir_store = 1'b0; reg_sel = 3'd0;
    ix = 16'h0; iy = 16'h0; pc = 16'h0; reg_rdata = 8'h0;
    cur_d = 8'h0; cur_memv = 8'h0; n_wait = 0;
    repeat (2) @(negedge clk);
    check_idle_reset("reset");
    rst = 1'b0;

    // Table-driven transactions, memory ready every cycle.
    for (int i = 0; i < 6; i++) begin
      run_txn(vecs[i], 0);
      check_txn(vecs[i], vecs[i].exp_done, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d wz_first_calc", i), wz_calc, vecs[i].exp_wz);
    end

    // Illegal register code: one-cycle error, nothing else moves.
    @(negedge clk);
    reg_sel = 3'd6; dir_store = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("illegal err_c1", err_illegal, 1);
    chk("illegal busy_c1", busy, 0);
    chk("illegal rdwr_c1", {mem_rd, mem_wr}, 2'b00);
    @(negedge clk);
    chk("illegal err_c2", err_illegal, 0);
    chk("illegal busy_c2", busy, 0);
    chk("illegal rdwr_c2", {mem_rd, mem_wr}, 2'b00);

    // Three wait states on both memory phases.
    n_wait = 3;
    run_txn(vecs[0], 0);
    check_txn(vecs[0], 15, "wait");
    n_wait = 0;

    // Second start while busy must be ignored.
    run_txn(vecs[4], 3);
    check_txn(vecs[4], 9, "busy_start");

    // Reset asserted during CALC.
    @(negedge clk);
    is_Y = 1'b0; dir_store = 1'b0; reg_sel = 3'd7; ix = 16'h1000; pc = 16'h0100;
    cur_d = 8'h05; cur_memv = 8'hAB; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("midrst in_calc busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle_reset("midrst");
    cnt_we = 0; cnt_done = 0; cnt_pc = 0;
    repeat (15) begin
      @(negedge clk);
      if (reg_we) cnt_we++;
      if (done) cnt_done++;
      if (pc_inc) cnt_pc++;
    end
    chk("midrst reg_we_after", cnt_we, 0);
    chk("midrst done_after", cnt_done, 0);
    chk("midrst pc_inc_after", cnt_pc, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
